// File: rtl/dmem_responder_pkg.sv
// Shared constants for the data-memory responder: region select, MMIO word
// offsets and STATUS register bit positions.
package dmem_responder_pkg;

   // The top address bit of the dmem port picks the region.
   typedef enum logic {
      REGION_RAM  = 1'b0,
      REGION_MMIO = 1'b1
   } region_e;

   localparam int MMIO_OFF_LSB = 2;
   localparam int MMIO_OFF_W   = 3;

   localparam logic [MMIO_OFF_W-1:0] MMIO_CONSOLE = 3'd0;
   localparam logic [MMIO_OFF_W-1:0] MMIO_STATUS  = 3'd1;
   localparam logic [MMIO_OFF_W-1:0] MMIO_CYC_LO  = 3'd2;
   localparam logic [MMIO_OFF_W-1:0] MMIO_CYC_HI  = 3'd3;
   localparam logic [MMIO_OFF_W-1:0] MMIO_HALT    = 3'd4;

   localparam int STATUS_FULL_BIT  = 0;
   localparam int STATUS_EMPTY_BIT = 1;
   localparam int STATUS_OVF_BIT   = 2;
   localparam int STATUS_COUNT_LSB = 8;

   function automatic region_e region_of(input logic msb);
      return region_e'(msb);
   endfunction

endpackage

// File: rtl/dmem_responder_sync_fifo.sv
// Synchronous FIFO with occupancy count and a flag for pushes that were
// dropped because the FIFO was full and not popping in the same cycle.
module sync_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic [DW-1:0]              i_push_data,
   input  logic                       i_pop,
   output logic [DW-1:0]              o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_dropped
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_ONE  = 1;
   localparam logic [AW:0] CNT_FULL = DEPTH;

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   logic w_pop;
   logic w_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_FULL);
   assign o_count   = r_count;
   assign w_pop     = i_pop && !o_empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
   assign w_push    = i_push && (!o_full || w_pop);
   assign o_dropped = i_push && o_full && !w_pop;
   assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_push_data;
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: word RAM plus an MMIO
// window holding the console FIFO, a free-running cycle counter and HALT.
module dmem_responder
   import dmem_responder_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DADDR      = 16,
   parameter int RAM_WORDS  = 4096,
   parameter int FIFO_DEPTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DADDR-1:0] dmem_addr,
   input  logic [WIDTH-1:0] dmem_wdata,
   input  logic             dmem_wr_en,
   output logic [WIDTH-1:0] dmem_rdata,
   output logic             con_valid,
   output logic [7:0]       con_data,
   input  logic             con_ready,
   output logic             halt,
   output logic [WIDTH-1:0] halt_code
);

   localparam int RAW = $clog2(RAM_WORDS);
   localparam int CW  = $clog2(FIFO_DEPTH) + 1;

   logic [WIDTH-1:0] r_ram [RAM_WORDS];
   logic [63:0]      r_cycle;
   logic             r_halt;
   logic [WIDTH-1:0] r_halt_code;
   logic             r_ovf;

   logic                  w_is_mmio;
   logic [RAW-1:0]        w_ram_idx;
   logic [MMIO_OFF_W-1:0] w_off;
   logic                  w_wr;
   logic                  w_ram_we;
   logic                  w_con_push;
   logic                  w_status_wr;
   logic                  w_halt_wr;
   logic                  w_ovf_clr;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [CW-1:0]         w_fifo_count;
   logic [7:0]            w_fifo_head;
   logic                  w_dropped;
   logic [WIDTH-1:0]      w_status;
   logic                  w_unused;

   assign w_is_mmio = (region_of(dmem_addr[DADDR-1]) == REGION_MMIO);
   assign w_ram_idx = dmem_addr[RAW+1:2];
   assign w_off     = dmem_addr[MMIO_OFF_LSB +: MMIO_OFF_W];
   assign w_unused  = ^dmem_addr;

   // Once halted the program can no longer change any state through stores.
   assign w_wr        = dmem_wr_en && !r_halt;
   assign w_ram_we    = w_wr && !w_is_mmio;
   assign w_con_push  = w_wr && w_is_mmio && (w_off == MMIO_CONSOLE);
   assign w_status_wr = w_wr && w_is_mmio && (w_off == MMIO_STATUS);
   assign w_halt_wr   = w_wr && w_is_mmio && (w_off == MMIO_HALT);
   assign w_ovf_clr   = w_status_wr && dmem_wdata[STATUS_OVF_BIT];

   // Console handshake: the head byte transfers at a rising edge where
   // con_valid and con_ready are both high; con_data holds while con_ready is low.
   sync_fifo #(
      .DW    (8),
      .DEPTH (FIFO_DEPTH)
   ) u_con_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_con_push),
      .i_push_data (dmem_wdata[7:0]),
      .i_pop       (con_ready),
      .o_head      (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count),
      .o_dropped   (w_dropped)
   );

   assign con_valid = !w_fifo_empty;
   assign con_data  = w_fifo_head;
   assign halt      = r_halt;
   assign halt_code = r_halt_code;

   always_ff @(posedge clk) begin
      if (w_ram_we) r_ram[w_ram_idx] <= dmem_wdata;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cycle     <= '0;
         r_halt      <= 1'b0;
         r_halt_code <= '0;
         r_ovf       <= 1'b0;
      end else begin
         if (!r_halt) r_cycle <= r_cycle + 64'd1;
         if (w_halt_wr) begin
            r_halt      <= 1'b1;
            r_halt_code <= dmem_wdata;
         end
         // A drop in the same cycle as a clear leaves overflow set.
         if (w_dropped)      r_ovf <= 1'b1;
         else if (w_ovf_clr) r_ovf <= 1'b0;
      end
   end

   always_comb begin
      w_status = '0;
      w_status[STATUS_FULL_BIT]           = w_fifo_full;
      w_status[STATUS_EMPTY_BIT]          = w_fifo_empty;
      w_status[STATUS_OVF_BIT]            = r_ovf;
      w_status[STATUS_COUNT_LSB +: CW]    = w_fifo_count;
   end

   always_comb begin
      dmem_rdata = '0;
      if (!w_is_mmio) begin
         dmem_rdata = r_ram[w_ram_idx];
      end else begin
         case (w_off)
            MMIO_STATUS: dmem_rdata = w_status;
            MMIO_CYC_LO: dmem_rdata = WIDTH'(r_cycle[31:0]);
            MMIO_CYC_HI: dmem_rdata = WIDTH'(r_cycle[63:32]);
            MMIO_HALT:   dmem_rdata = r_halt_code;
            default:     dmem_rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a behavioural
// model: word-array RAM, byte queue console, cycle count and halt flag.
module tb_dmem_responder;

   localparam int WIDTH      = 32;
   localparam int DADDR      = 16;
   localparam int RAM_WORDS  = 4096;
   localparam int FIFO_DEPTH = 8;

   logic             clk;
   logic             reset;
   logic [DADDR-1:0] dmem_addr;
   logic [WIDTH-1:0] dmem_wdata;
   logic             dmem_wr_en;
   logic [WIDTH-1:0] dmem_rdata;
   logic             con_valid;
   logic [7:0]       con_data;
   logic             con_ready;
   logic             halt;
   logic [WIDTH-1:0] halt_code;

   dmem_responder #(
      .WIDTH      (WIDTH),
      .DADDR      (DADDR),
      .RAM_WORDS  (RAM_WORDS),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .dmem_addr  (dmem_addr),
      .dmem_wdata (dmem_wdata),
      .dmem_wr_en (dmem_wr_en),
      .dmem_rdata (dmem_rdata),
      .con_valid  (con_valid),
      .con_data   (con_data),
      .con_ready  (con_ready),
      .halt       (halt),
      .halt_code  (halt_code)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // behavioural model
   logic [WIDTH-1:0] ram_m [RAM_WORDS];
   bit               ram_known [RAM_WORDS];
   logic [7:0]       exp_q [$];
   bit               m_ovf;
   bit               m_halt;
   logic [WIDTH-1:0] m_code;
   longint unsigned  m_cyc;

   int n_assert = 0;
   int n_fail   = 0;

   logic [WIDTH-1:0] obs_rdata;
   logic             obs_valid;
   logic [7:0]       obs_data;
   logic             obs_halt;
   logic [WIDTH-1:0] obs_code;

   localparam logic [15:0] A_CON    = 16'h8000;
   localparam logic [15:0] A_STATUS = 16'h8004;
   localparam logic [15:0] A_CYC_LO = 16'h8008;
   localparam logic [15:0] A_CYC_HI = 16'h800C;
   localparam logic [15:0] A_HALT   = 16'h8010;
   localparam logic [15:0] A_IDLE   = 16'h8014;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf  = 0;
      m_halt = 0;
      m_code = '0;
      m_cyc  = 0;
   endtask

   task automatic model_read(input logic [15:0] a, output logic [WIDTH-1:0] v, output bit known);
      int idx;
      int n;
      known = 1;
      v = '0;
      n = exp_q.size();
      if (a[15] == 1'b0) begin
         idx   = (int'(a) / 4) % RAM_WORDS;
         known = ram_known[idx];
         v     = ram_m[idx];
      end else begin
         case ((int'(a) / 4) % 8)
            1: v = WIDTH'(n * 256 + (m_ovf ? 4 : 0) + (n == 0 ? 2 : 0) + (n == FIFO_DEPTH ? 1 : 0));
            2: v = WIDTH'(m_cyc & 64'hFFFF_FFFF);
            3: v = WIDTH'(m_cyc >> 32);
            4: v = m_code;
            default: v = '0;
         endcase
      end
   endtask

   // driver: one core cycle; outputs are checked at the falling edge, then the
   // model advances to what the next rising edge must produce.
   task automatic cyc(input logic [15:0] a, input logic [WIDTH-1:0] wd, input logic we, input logic rdy);
      logic [WIDTH-1:0] exp_rd;
      bit known, push, pop, drop, clr, hw;
      logic [WIDTH-1:0] hcode;
      dmem_addr  = a;
      dmem_wdata = wd;
      dmem_wr_en = we;
      con_ready  = rdy;
      @(negedge clk);
      obs_rdata = dmem_rdata;
      obs_valid = con_valid;
      obs_data  = con_data;
      obs_halt  = halt;
      obs_code  = halt_code;
      model_read(a, exp_rd, known);
      if (known) chk($sformatf("rdata@%h", a), 64'(dmem_rdata), 64'(exp_rd));
      chk("con_valid", 64'(con_valid), 64'(exp_q.size() != 0));
      chk("con_data", 64'(con_data), 64'(exp_q.size() != 0 ? exp_q[0] : 8'h00));
      chk("halt", 64'(halt), 64'(m_halt));
      chk("halt_code", 64'(halt_code), 64'(m_code));
      push = 0; clr = 0; hw = 0; hcode = '0;
      if (!m_halt && we) begin
         if (a[15] == 1'b0) begin
            ram_m[(int'(a) / 4) % RAM_WORDS]     = wd;
            ram_known[(int'(a) / 4) % RAM_WORDS] = 1;
         end else begin
            case ((int'(a) / 4) % 8)
               0: push = 1;
               1: clr = wd[2];
               4: begin hw = 1; hcode = wd; end
               default: ;
            endcase
         end
      end
      pop  = (exp_q.size() != 0) && rdy;
      drop = push && (exp_q.size() == FIFO_DEPTH) && !pop;
      if (!m_halt) m_cyc++;
      if (pop) void'(exp_q.pop_front());
      if (push && !drop) exp_q.push_back(wd[7:0]);
      if (drop) m_ovf = 1;
      else if (clr) m_ovf = 0;
      if (hw) begin m_halt = 1; m_code = hcode; end
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] a;
      logic [2:0]  off;
      int          sel;
      int          guard;
      logic [7:0]  drained [$];
      logic [WIDTH-1:0] ram10;

      reset = 1'b1; dmem_addr = A_CYC_LO; dmem_wdata = '0; dmem_wr_en = 1'b0; con_ready = 1'b0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_con_valid", 64'(con_valid), 64'd0);
      chk("rst_con_data", 64'(con_data), 64'd0);
      chk("rst_halt", 64'(halt), 64'd0);
      chk("rst_halt_code", 64'(halt_code), 64'd0);
      chk("rst_cyc_lo", 64'(dmem_rdata), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;

      // RAM store/load, byte-offset alias, same-cycle store+load
      cyc(16'h0010, 32'hDEADBEEF, 1, 0);
      cyc(16'h0010, 32'h0, 0, 0);
      chk("t1_load", 64'(obs_rdata), 64'hDEADBEEF);
      cyc(16'h0013, 32'h0, 0, 0);
      chk("t1_load_b3", 64'(obs_rdata), 64'hDEADBEEF);
      cyc(16'h0010, 32'hCAFEF00D, 1, 0);
      chk("t1_rw_old", 64'(obs_rdata), 64'hDEADBEEF);
      cyc(16'h0010, 32'h0, 0, 0);
      chk("t1_rw_new", 64'(obs_rdata), 64'hCAFEF00D);

      // console push and drain
      cyc(A_CON, 32'h48, 1, 0);
      chk("t2_valid_push_cycle", 64'(obs_valid), 64'd0);
      cyc(A_CON, 32'h69, 1, 0);
      chk("t2_valid_next", 64'(obs_valid), 64'd1);
      cyc(A_STATUS, 32'h0, 0, 0);
      chk("t2_status", 64'(obs_rdata), 64'h200);
      cyc(A_IDLE, 32'h0, 0, 1);
      chk("t2_byte0", 64'(obs_data), 64'h48);
      cyc(A_IDLE, 32'h0, 0, 1);
      chk("t2_byte1", 64'(obs_data), 64'h69);
      cyc(A_IDLE, 32'h0, 0, 1);
      chk("t2_empty", 64'(obs_valid), 64'd0);

      // overflow
      for (int i = 1; i <= 9; i++) cyc(A_CON, WIDTH'(i), 1, 0);
      cyc(A_STATUS, 32'h0, 0, 0);
      chk("t3_status", 64'(obs_rdata), 64'h805);
      drained.delete();
      for (int i = 0; i < 9; i++) begin
         cyc(A_IDLE, 32'h0, 0, 1);
         if (obs_valid) drained.push_back(obs_data);
      end
      chk("t3_drain_len", 64'(drained.size()), 64'd8);
      for (int i = 0; i < drained.size(); i++) chk("t3_drain", 64'(drained[i]), 64'(i + 1));
      cyc(A_STATUS, 32'h4, 1, 0);
      cyc(A_STATUS, 32'h0, 0, 0);
      chk("t3_ovf_clr", 64'(obs_rdata), 64'h002);

      // push and pop together while full
      for (int i = 0; i < 8; i++) cyc(A_CON, WIDTH'(8'h11 + i), 1, 0);
      cyc(A_CON, 32'hAA, 1, 1);
      cyc(A_STATUS, 32'h0, 0, 0);
      chk("t4_status", 64'(obs_rdata), 64'h801);
      drained.delete();
      for (int i = 0; i < 9; i++) begin
         cyc(A_IDLE, 32'h0, 0, 1);
         if (obs_valid) drained.push_back(obs_data);
      end
      chk("t4_drain_len", 64'(drained.size()), 64'd8);
      if (drained.size() == 8) chk("t4_last", 64'(drained[7]), 64'hAA);

      // randomized traffic
      for (int i = 0; i < 16; i++) cyc(16'(i * 4), $urandom, 1, 0);
      for (int n = 0; n < 400; n++) begin
         sel = $urandom_range(0, 9);
         if (sel < 5) begin
            a = 16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) a = a | 16'h4000;
            cyc(a, $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
         end else begin
            case ($urandom_range(0, 6))
               0, 1, 2: off = 3'd0;
               3: off = 3'd1;
               4: off = 3'd2;
               5: off = 3'd3;
               default: off = 3'($urandom_range(5, 7));
            endcase
            a = 16'h8000 | 16'($urandom_range(0, 1023) * 32) | 16'({off, 2'b00});
            cyc(a, $urandom, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0));
         end
      end
      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         cyc(A_IDLE, 32'h0, 0, 1);
         guard++;
      end
      chk("rand_drained", 64'(exp_q.size()), 64'd0);
      cyc(A_STATUS, 32'h4, 1, 0);

      // halt
      for (int i = 0; i < 3; i++) cyc(A_CON, WIDTH'(8'h31 + i), 1, 0);
      cyc(16'h0010, 32'h0, 0, 0);
      ram10 = ram_m[4];
      cyc(A_HALT, 32'h2A, 1, 0);
      chk("t5_halt_same_cycle", 64'(obs_halt), 64'd0);
      cyc(A_IDLE, 32'h0, 0, 0);
      chk("t5_halt", 64'(obs_halt), 64'd1);
      chk("t5_halt_code", 64'(obs_code), 64'h2A);
      cyc(16'h0010, 32'h12345678, 1, 0);
      cyc(16'h0010, 32'h0, 0, 0);
      chk("t5_ram_frozen", 64'(obs_rdata), 64'(ram10));
      cyc(A_CON, 32'h55, 1, 0);
      cyc(A_HALT, 32'h99, 1, 0);
      cyc(A_STATUS, 32'h0, 0, 0);
      chk("t5_status", 64'(obs_rdata), 64'h300);
      for (int i = 0; i < 10; i++) cyc(A_CYC_LO, 32'h0, 0, 0);
      chk("t5_code_kept", 64'(obs_code), 64'h2A);

      // async reset while draining
      cyc(A_IDLE, 32'h0, 0, 1);
      dmem_addr = A_IDLE; con_ready = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("t6_con_valid", 64'(con_valid), 64'd0);
      chk("t6_con_data", 64'(con_data), 64'd0);
      chk("t6_halt", 64'(halt), 64'd0);
      chk("t6_halt_code", 64'(halt_code), 64'd0);
      model_reset();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;
      dmem_addr = A_CYC_LO;
      #1;
      chk("t6_cyc_lo", 64'(dmem_rdata), 64'd0);
      dmem_addr = A_CYC_HI;
      #1;
      chk("t6_cyc_hi", 64'(dmem_rdata), 64'd0);
      cyc(16'h0010, 32'h0, 0, 0);
      chk("t6_ram_kept", 64'(obs_rdata), 64'(ram10));
      cyc(A_CYC_LO, 32'h0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Responder side of the core's data-memory port. Serves word loads and stores from the single-cycle core: dmem_addr, dmem_wdata and dmem_wr_en in, dmem_rdata out.
- Contains the data RAM and a small MMIO window:
  - console byte FIFO drained by the bench/top,
  - 64-bit cycle counter,
  - sticky halt register that ends a program run.
- Sits beside the core at SoC/testbench top.

Parameters:
- WIDTH, 32, data word width.
- DADDR, 16, byte-address width of the dmem port.
- RAM_WORDS, 4096, data RAM depth in words; power of two, ≤ 2^(DADDR-3).
- FIFO_DEPTH, 8, console FIFO entries; power of two, ≥ 2.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high reset.
- dmem_addr  in  DADDR  byte address from core; bits [1:0] ignored.
- dmem_wdata  in  WIDTH  store data.
- dmem_wr_en  in  1  store strobe, sampled at rising edge.
- dmem_rdata  out  WIDTH  load data, combinational from dmem_addr.
- con_valid  out  1  console FIFO non-empty.
- con_data  out  8  console FIFO head byte.
- con_ready  in  1  consumer accepts head this cycle.
- halt  out  1  program has written HALT.
- halt_code  out  WIDTH  value written to HALT.

Behaviour:
- Region decode:
  - dmem_addr[DADDR-1]=0 selects RAM. Word index is dmem_addr[log2(RAM_WORDS)+1:2]; upper bits alias.
  - dmem_addr[DADDR-1]=1 selects MMIO; register selected by dmem_addr[4:2].
- Reads: purely combinational, zero latency. The single-cycle core consumes dmem_rdata in the same cycle. Load and store to the same word in one cycle returns the pre-write value.
- RAM: write at posedge when dmem_wr_en and RAM region. Contents are not reset and are retained across reset.
- MMIO map (word offset: read / write):
  - 0 CONSOLE: reads 0 / pushes dmem_wdata[7:0].
  - 1 STATUS: reads {.., count[11:8], overflow[2], empty[1], full[0]} / writing 1 to bit2 clears overflow.
  - 2 CYCLE_LO: counter[31:0] / ignored.
  - 3 CYCLE_HI: counter[63:32] / ignored.
  - 4 HALT: reads halt_code / sets halt=1 and halt_code=dmem_wdata.
  - 5-7: read 0 / writes ignored.
- Cycle counter: 64-bit; increments every cycle while halt=0, frozen once halt=1; wraps 2^64-1 → 0.
- Halt:
  - Sticky until reset.
  - After halt=1, all writes are ignored: RAM, console and HALT. Reads still work and the FIFO still drains.
  - The HALT write cycle itself takes effect; halt is visible the next cycle.
- Console FIFO:
  - Push on CONSOLE write; pop at posedge when con_valid && con_ready.
  - con_valid = (count != 0). con_data = head byte when valid, 8'h00 when empty.
  - No bypass: a push into an empty FIFO is visible on con_valid the following cycle.
  - Push when full and no pop: byte dropped, overflow set (sticky).
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when non-full and non-empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits and saturates naturally at FIFO_DEPTH.
- Overflow set and clear in the same cycle: set wins.
- Reset (async assert, any time including mid-drain): FIFO emptied, count=0, overflow=0, counter=0, halt=0, halt_code=0, con_valid=0, con_data=0. RAM is untouched.

Decomposition:
- lib_pkg gains:
  - MMIO word-offset constants (MMIO_CONSOLE, MMIO_STATUS, MMIO_CYC_LO, MMIO_CYC_HI, MMIO_HALT),
  - STATUS bit-position constants,
  - the region-select bit definition.
- One sub-module: sync_fifo, parameterised by data width and depth. Outputs push/pop/full/empty/count and a dropped-push flag.
- RAM array, decode, counter and halt logic stay in dmem_responder.

Test Plan:
1. RAM: store 0xDEADBEEF at 0x0010, then load 0x0010 → 0xDEADBEEF. Load 0x0013 → same word. Store/load same address in one cycle → old value.
2. Console: con_ready=0; write 'H','i' (0x48, 0x69) to 0x8000 → con_valid=1 one cycle after first push, STATUS count=2. Raise con_ready → con_data 0x48 then 0x69, con_valid drops after second pop.
3. Overflow: con_ready=0; push 9 bytes 0x01..0x09 with FIFO_DEPTH=8 → STATUS full=1, overflow=1, drained sequence 0x01..0x08. Write 0x4 to STATUS → overflow=0.
4. Full push+pop: fill to 8, then push 0xAA with con_ready=1 in the same cycle → count stays 8, overflow=0, 0xAA drains last.
5. Halt: write 0x0000002A to 0x8010 → next cycle halt=1, halt_code=0x2A. Subsequent RAM write to 0x0010 has no effect. CYCLE_LO reads stay constant over 10 cycles.
6. Async reset mid-drain with 3 bytes queued → con_valid=0 immediately, halt=0, counter reads 0 after release, RAM word at 0x0010 still holds its value.
